// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the shared PS/2 clock/data pins through open-drain enables. It sends the
// request-to-send sequence, shifts the byte out on device clock falling edges,
// then samples the device ACK. A transaction that stalls is ended by an overall timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic          fe;
    logic [9:0]    shreg;     // {stop, parity, data}, shifted out LSB first
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          ack_smp;   // ACK seen on the 11th clock; published on done

    assign tx_ready = (state == S_IDLE);
    assign fe       = clk_prev & ~clk_s2;

    // Two-flop synchronizers for the asynchronous pins; reset to the idle-high bus level
    // so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    // Transaction sequencer: all pin enables and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ack_smp     <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        shreg      <= {1'b1, ~^tx_data, tx_data};
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= '0;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;   // start bit while clock still held
                        state       <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;        // hand the clock to the device
                    to_cnt     <= '0;
                    bit_cnt    <= '0;
                    state      <= S_SEND;
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    if (to_cnt == TO_LAST) begin
                        // Timeout wins over any edge arriving this cycle.
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        ack_ok      <= 1'b0;
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == S_SEND && fe) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b0, shreg[9:1]};
                            bit_cnt     <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9)
                                state <= S_ACK;
                        end else if (state == S_ACK && fe) begin
                            ack_smp <= ~data_s2;
                            state   <= S_WAIT_IDLE;
                        end else if (state == S_WAIT_IDLE && clk_s2 && data_s2) begin
                            ack_ok <= ack_smp;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: stimulus issues transfers and queues expected frames/results; a device
// model clocks frames in and compares bits; a monitor checks every done pulse.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 4000;
    localparam int HALF = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_ok, err_timeout;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    int   dev_mode = 0;       // 0 ACK, 1 NACK, 2 silent, 3 abort after 4th clock
    logic abort_req = 1'b0;
    logic abort_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [9:0] frame_q[$];
    logic [1:0] res_q[$];     // {ack_ok, err_timeout}

    // Open-drain bus: either side may pull low.
    assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .ack_ok(ack_ok), .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bits as the device should see them, in wire order: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = (($countones(b) % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Device model: checks the request-to-send phase, then acts according to dev_mode.
    initial begin : device
        forever begin
            int n, r, c;
            logic [9:0] got;
            @(negedge clk);
            if (ps2_clk_oe && !ps2_data_oe && !rst) begin
                n = 1;
                @(negedge clk);
                while (ps2_clk_oe && !ps2_data_oe && n < 100) begin n++; @(negedge clk); end
                chk("inhibit_len", n, INH);
                r = 0;
                while (ps2_clk_oe && ps2_data_oe && r < 10) begin r++; @(negedge clk); end
                chk("req_len", r, 1);
                chk("start_bit_held", {ps2_clk_oe, ps2_data_oe}, 2'b01);
                if (dev_mode == 2) begin
                    c = 0;
                    while (!done && c < TO + 100) begin c++; @(negedge clk); end
                    chk("timeout_latency", c, TO);
                end else begin
                    repeat (5) @(negedge clk);
                    got = '0;
                    for (int k = 0; k < 10; k++) begin
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        if (dev_mode == 3 && k == 3) begin
                            abort_req = 1'b1;
                            c = 0;
                            while (!abort_ack && c < 1000) begin c++; @(negedge clk); end
                            abort_req   = 1'b0;
                            dev_clk_low = 1'b0;
                            break;
                        end
                        dev_clk_low = 1'b0;
                        got[k] = ps2_data_in;   // device samples on the rising clock
                        repeat (HALF) @(negedge clk);
                    end
                    if (dev_mode != 3) begin
                        chk("frame_pending", frame_q.size() > 0, 1);
                        if (frame_q.size() > 0) chk("frame_bits", got, frame_q.pop_front());
                        if (dev_mode == 0) dev_data_low = 1'b1;
                        repeat (5) @(negedge clk);
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                        repeat (3) @(negedge clk);
                        dev_data_low = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expected result.
    initial begin : monitor
        logic prev_done;
        logic [1:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) begin
                chk("post_done_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                chk("post_done_ready", tx_ready, 1);
                chk("done_one_cycle", done, 0);
            end
            if (err_timeout && !done) chk("timeout_without_done", 1, 0);
            if (done) begin
                chk("result_pending", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    e = res_q.pop_front();
                    chk("ack_ok", ack_ok, e[1]);
                    chk("err_timeout", err_timeout, e[0]);
                    chk("busy_at_done", busy, 0);
                end
            end
            prev_done = done;
        end
    end

    task automatic push_expect(input logic [7:0] b, input int mode);
        if (mode <= 1) frame_q.push_back(frame_of(b));
        if (mode <= 2) res_q.push_back({mode == 0, mode == 2});
    endtask

    task automatic send(input logic [7:0] b, input int mode);
        int c;
        c = 0;
        dev_mode = mode;
        while (!tx_ready && c < 1000) begin @(negedge clk); c++; end
        push_expect(b, mode);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_busy", busy, 1);
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done && c < 20000) begin @(negedge clk); c++; end
        chk({name, "_done_seen"}, done, 1);
        @(negedge clk);
    endtask

    initial begin : stim
        int c, n_rdy;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("rst_status", {busy, done, ack_ok, err_timeout}, 4'b0000);
        chk("rst_ready", tx_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        send(8'hED, 0); wait_done("ed_ack");
        send(8'h00, 0); wait_done("par_00");
        send(8'hFF, 0); wait_done("par_ff");
        send(8'h01, 0); wait_done("par_01");
        send(8'h80, 0); wait_done("par_80");
        send(8'h5A, 1); wait_done("nack");
        send(8'hED, 0); wait_done("ack_before_to");
        send(8'h12, 2); wait_done("timeout");

        // Reset in the middle of a frame, after the fourth device clock.
        send(8'h3C, 3);
        c = 0;
        while (!abort_req && c < 3000) begin @(negedge clk); c++; end
        chk("abort_point_reached", abort_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", tx_ready, 1);
        rst = 1'b0;
        abort_ack = 1'b1;
        c = 0;
        while (abort_req && c < 100) begin @(negedge clk); c++; end
        abort_ack = 1'b0;
        repeat (20) @(negedge clk);
        send(8'hFF, 0); wait_done("after_reset");

        // Back-to-back with tx_valid held: second accept only once IDLE again.
        dev_mode = 0;
        push_expect(8'hF4, 0);
        push_expect(8'hED, 0);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hED;
        n_rdy = 0;
        c = 0;
        while (!done && c < 20000) begin
            if (tx_ready) n_rdy++;
            @(negedge clk);
            c++;
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_ready_low", n_rdy, 0);
        @(negedge clk);
        chk("b2b_ready_after", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_second_accept", busy, 1);
        wait_done("b2b_second");

        // Randomized bytes with random ACK/NACK responses.
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send(b, int'($urandom_range(0, 1)));
            wait_done("random");
        end

        repeat (20) @(negedge clk);
        chk("frames_drained", frame_q.size(), 0);
        chk("results_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
